// File: rtl/ans_encoder.sv
// Streaming rANS encoder. Accepts symbols, emits SYM_WIDTH-bit renormalisation
// chunks and, at frame end, the final state MSB chunk first. The decoder reads
// the reversed stream. Its frequency tables match ans_decoder.
module ans_encoder #(
  parameter int SYM_WIDTH   = 4,
  parameter int CNT_WIDTH   = 4,
  parameter int SYM_COUNT   = 16,
  parameter int STATE_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ena,
  input  logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
  input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
  input  logic [SYM_WIDTH-1:0]                   in,
  input  logic                                   in_last,
  input  logic                                   in_vld,
  output logic                                   in_rdy,
  output logic [SYM_WIDTH-1:0]                   out,
  output logic                                   out_last,
  output logic                                   out_vld,
  input  logic                                   out_rdy,
  output logic                                   err
);

  localparam int CUM_W    = CNT_WIDTH + SYM_WIDTH;
  localparam int WIDE_W   = STATE_WIDTH + CNT_WIDTH + SYM_WIDTH;
  localparam int N_CHUNKS = STATE_WIDTH / SYM_WIDTH;
  localparam int DCNT_W   = $clog2(STATE_WIDTH + 1);
  localparam int FCNT_W   = $clog2(N_CHUNKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_RENORM, S_DIV, S_UPDATE, S_FLUSH} state_t;

  state_t                 r_state, w_next_state;
  logic [STATE_WIDTH-1:0] r_x;
  logic [SYM_WIDTH-1:0]   r_sym;
  logic                   r_last;
  logic                   r_frame_active;
  logic                   r_err;
  logic [STATE_WIDTH-1:0] r_q;
  logic [CNT_WIDTH-1:0]   r_rem;
  logic [DCNT_W-1:0]      r_div_cnt;
  logic [FCNT_W-1:0]      r_flush_cnt;

  logic [SYM_WIDTH-1:0]   w_sel_sym;
  logic [CNT_WIDTH-1:0]   w_count;
  logic [CUM_W-1:0]       w_lo;
  logic [CUM_W-1:0]       w_m;
  logic                   w_renorm;
  logic [CNT_WIDTH:0]     w_trial;
  logic [CNT_WIDTH:0]     w_trial_sub;
  logic                   w_trial_ge;
  logic [WIDE_W-1:0]      w_update;
  logic                   w_flush_final;
  logic                   w_in_fire;
  logic                   w_out_fire;

  // Table lookups: the symbol on the input in IDLE, the latched one afterwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_lo      = '0;
    w_sel_sym = (r_state == S_IDLE) ? in : r_sym;
    w_count   = counts_unpacked[int'(w_sel_sym)*CNT_WIDTH +: CNT_WIDTH];
    w_m       = cumulative_unpacked[(SYM_COUNT-1)*CUM_W +: CUM_W];
    if (r_sym != '0) begin
      w_lo = cumulative_unpacked[(int'(r_sym)-1)*CUM_W +: CUM_W];
    end
    w_renorm      = WIDE_W'(r_x) >= (WIDE_W'(w_count) << SYM_WIDTH);
    w_trial       = {r_rem, r_q[STATE_WIDTH-1]};
    w_trial_ge    = w_trial >= {1'b0, w_count};
    w_trial_sub   = w_trial - {1'b0, w_count};
    w_update      = WIDE_W'(r_q) * WIDE_W'(w_m) + WIDE_W'(w_lo) + WIDE_W'(r_rem);
    w_flush_final = r_flush_cnt == FCNT_W'(N_CHUNKS - 1);
  end

  // Port outputs are decoded from the frozen state, so they hold until accepted.
  always_comb begin
    in_rdy   = (r_state == S_IDLE);
    out_vld  = 1'b0;
    out_last = 1'b0;
    out      = '0;
    if (r_state == S_RENORM && w_renorm) begin
      out_vld = 1'b1;
      out     = r_x[SYM_WIDTH-1:0];
    end else if (r_state == S_FLUSH) begin
      out_vld  = 1'b1;
      out      = r_x[STATE_WIDTH-1 -: SYM_WIDTH];
      out_last = w_flush_final;
    end
    err        = r_err;
    w_in_fire  = ena && in_vld && in_rdy;
    w_out_fire = ena && out_vld && out_rdy;
  end

  // Next-state decode; ena low holds the current state.
  always_comb begin
    w_next_state = r_state;
    if (ena) begin
      case (r_state)
        S_IDLE:   if (w_in_fire && w_count != '0) w_next_state = S_RENORM;
        S_RENORM: if (!w_renorm) w_next_state = S_DIV;
        S_DIV:    if (r_div_cnt == DCNT_W'(STATE_WIDTH - 1)) w_next_state = S_UPDATE;
        S_UPDATE: w_next_state = r_last ? S_FLUSH : S_IDLE;
        S_FLUSH:  if (w_out_fire && w_flush_final) w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Coder state, divider and flush datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x            <= '0;
      r_sym          <= '0;
      r_last         <= 1'b0;
      r_frame_active <= 1'b0;
      r_err          <= 1'b0;
      r_q            <= '0;
      r_rem          <= '0;
      r_div_cnt      <= '0;
      r_flush_cnt    <= '0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_sym  <= in;
            r_last <= in_last;
            if (!r_frame_active) begin
              r_x            <= STATE_WIDTH'(w_m);
              r_frame_active <= 1'b1;
            end
            if (w_count == '0) r_err <= 1'b1;
          end
        end
        S_RENORM: begin
          if (w_renorm) begin
            if (out_rdy) r_x <= r_x >> SYM_WIDTH;
          end else begin
            r_q       <= r_x;
            r_rem     <= '0;
            r_div_cnt <= '0;
          end
        end
        S_DIV: begin
          r_rem     <= w_trial_ge ? w_trial_sub[CNT_WIDTH-1:0] : w_trial[CNT_WIDTH-1:0];
          r_q       <= {r_q[STATE_WIDTH-2:0], w_trial_ge};
          r_div_cnt <= r_div_cnt + 1'b1;
        end
        S_UPDATE: begin
          r_x         <= w_update[STATE_WIDTH-1:0];
          r_flush_cnt <= '0;
        end
        S_FLUSH: begin
          if (out_rdy) begin
            r_x         <= r_x << SYM_WIDTH;
            r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_flush_final) begin
              r_x            <= '0;
              r_frame_active <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_encoder.sv
// Directed bench for ans_encoder with counts 8,4,4,0... (M = 16).
module tb_ans_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [63:0] counts_unpacked;
  logic [127:0] cumulative_unpacked;
  logic [3:0]  in = '0;
  logic        in_last = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [3:0]  out;
  logic        out_last;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;
  logic [4:0] got[$];   // {out_last, out} per accepted chunk

  ans_encoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .counts_unpacked(counts_unpacked), .cumulative_unpacked(cumulative_unpacked),
    .in(in), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
    .out(out), .out_last(out_last), .out_vld(out_vld), .out_rdy(out_rdy),
    .err(err)
  );

  always #5 clk = ~clk;

  // Record every chunk that the sink accepts at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && ena && out_vld && out_rdy) got.push_back({out_last, out});
  end

  task automatic send_sym(input logic [3:0] s, input logic last);
    bit done = 0;
    @(posedge clk); #1;
    in = s; in_last = last; in_vld = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    in_vld = 1'b0; in_last = 1'b0;
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL send_sym: in_rdy=0 after 200 cycles, required 1"); end
  endtask

  task automatic wait_items(input int n, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (got.size() >= n) begin timed_out = 0; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({in_rdy, out_vld, out_last, out, err} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rdy/vld/last/out/err=%b %b %b %h %b, required 1 0 0 0 0",
               in_rdy, out_vld, out_last, out, err);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [4:0] exp[4] = '{5'h00, 5'h00, 5'h04, 5'h18};
    bit to;
    got.delete();
    send_sym(4'd1, 1'b1);
    wait_items(4, to);
    n_checks++;
    if (to || got.size() != 4) begin n_fail++; $display("FAIL single count: %0d chunks, required 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL single chunk%0d: got %h, required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_zeros_with_stall();
    logic [4:0] exp[4] = '{5'h00, 5'h00, 5'h04, 5'h10};
    bit to;
    got.delete();
    send_sym(4'd0, 1'b0);
    send_sym(4'd0, 1'b1);
    // Freeze mid-divide: no progress, in_rdy stays low.
    repeat (3) @(posedge clk); #1;
    ena = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b0) begin
        n_fail++; $display("FAIL ena_hold: in_rdy=%b out_vld=%b, required 0 0", in_rdy, out_vld);
      end
    end
    @(posedge clk); #1; ena = 1'b1;
    wait_items(4, to);
    n_checks++;
    if (to || got.size() != 4) begin n_fail++; $display("FAIL zeros count: %0d chunks, required 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL zeros chunk%0d: got %h, required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_renorm();
    logic [4:0] exp[5] = '{5'h08, 5'h00, 5'h00, 5'h01, 5'h18};
    bit to;
    got.delete();
    send_sym(4'd1, 1'b0);
    send_sym(4'd1, 1'b1);
    wait_items(5, to);
    n_checks++;
    if (to || got.size() != 5) begin n_fail++; $display("FAIL renorm count: %0d chunks, required 5", got.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL renorm chunk%0d: got %h, required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp[5] = '{5'h08, 5'h00, 5'h00, 5'h01, 5'h18};
    bit to = 1;
    got.delete();
    send_sym(4'd1, 1'b0);
    out_rdy = 1'b0;
    send_sym(4'd1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_vld) begin to = 0; break; end
    end
    n_checks++;
    if (to) begin n_fail++; $display("FAIL bp_wait: out_vld=0 after 50 cycles, required 1"); end
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (out_vld !== 1'b1 || out !== 4'h8 || dut.r_x !== 16'd72) begin
        n_fail++;
        $display("FAIL bp_hold: vld=%b out=%h x=%0d, required 1 8 72", out_vld, out, dut.r_x);
      end
    end
    @(posedge clk); #1; out_rdy = 1'b1;
    wait_items(5, to);
    n_checks++;
    if (to || got.size() != 5) begin n_fail++; $display("FAIL bp count: %0d chunks, required 5", got.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL bp chunk%0d: got %h, required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_zero_count();
    logic [4:0] exp[4] = '{5'h00, 5'h00, 5'h04, 5'h18};
    bit to;
    got.delete();
    send_sym(4'd5, 1'b0);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || in_rdy !== 1'b1 || out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_count: err=%b in_rdy=%b out_vld=%b, required 1 1 0", err, in_rdy, out_vld);
      end
    end
    send_sym(4'd1, 1'b1);
    wait_items(4, to);
    n_checks++;
    if (to || got.size() != 4) begin n_fail++; $display("FAIL after_err count: %0d chunks, required 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL after_err chunk%0d: got %h, required %h", i, got[i], exp[i]); end
    end
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: err=%b, required 1", err); end
  endtask

  task automatic test_reset_mid_div();
    logic [4:0] exp[4] = '{5'h00, 5'h00, 5'h04, 5'h1C};
    bit to;
    got.delete();
    send_sym(4'd1, 1'b1);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_rdy, out_vld, out_last, out, err} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_div_reset: rdy/vld/last/out/err=%b %b %b %h %b, required 1 0 0 0 0",
               in_rdy, out_vld, out_last, out, err);
    end
    @(negedge clk); rst_n = 1'b1;
    got.delete();
    send_sym(4'd2, 1'b1);
    wait_items(4, to);
    n_checks++;
    if (to || got.size() != 4) begin n_fail++; $display("FAIL post_reset count: %0d chunks, required 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL post_reset chunk%0d: got %h, required %h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    counts_unpacked = '0;
    counts_unpacked[3:0]  = 4'd8;
    counts_unpacked[7:4]  = 4'd4;
    counts_unpacked[11:8] = 4'd4;
    cumulative_unpacked = '0;
    cumulative_unpacked[7:0]   = 8'd8;
    cumulative_unpacked[15:8]  = 8'd12;
    for (int j = 2; j < 16; j++) cumulative_unpacked[j*8 +: 8] = 8'd16;

    test_reset();
    test_single();
    test_zeros_with_stall();
    test_renorm();
    test_backpressure();
    test_zero_count();
    test_reset_mid_div();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ans_encoder.md
Name: ans_encoder

Overview:
- Streaming rANS encoder: the transmit-side counterpart of the team's ans_decoder. Consumes symbols, emits SYM_WIDTH-bit renormalisation chunks plus a final state flush, using the same counts/cumulative frequency tables.
- Output stream is LIFO with respect to decoding. The host reverses the full frame of emitted chunks before feeding ans_decoder: final state first, least significant chunk first.

Parameters:
- SYM_WIDTH, 4, symbol width and output chunk width.
- CNT_WIDTH, 4, width of each per-symbol count.
- SYM_COUNT, 16, number of symbols.
- STATE_WIDTH, 16, coder state width; must be a multiple of SYM_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  when 0, all state holds.
- counts_unpacked  in  CNT_WIDTH*SYM_COUNT  count[j] at bits j*CNT_WIDTH.
- cumulative_unpacked  in  (CNT_WIDTH+SYM_WIDTH)*SYM_COUNT  inclusive prefix sums: cum[j] = count[0]+...+count[j].
- in  in  SYM_WIDTH  symbol to encode.
- in_last  in  1  marks the last symbol of the frame.
- in_vld  in  1  symbol valid.
- in_rdy  out  1  encoder can accept a symbol.
- out  out  SYM_WIDTH  emitted chunk.
- out_last  out  1  marks the final flush chunk.
- out_vld  out  1  chunk valid.
- out_rdy  in  1  sink accepts the chunk.
- err  out  1  sticky flag: a zero-count symbol was received.

Behaviour:
- Handshakes are standard valid/ready: a transfer occurs in any cycle where vld && rdy. out, out_last and out_vld hold stable until accepted.
- Definitions: M = cum[SYM_COUNT-1]. lo(s) = 0 if s==0, else cum[s-1]. c = count[s].
- Reset values: in_rdy=1, out=0, out_vld=0, out_last=0, err=0, state x=0, frame_active=0, FSM=IDLE.
- IDLE:
  - in_rdy=1.
  - On a transfer, latch s and last. If !frame_active, set x=M and frame_active=1 in that same cycle.
  - If c==0: set err=1, drop the symbol, stay in IDLE.
  - Otherwise go to RENORM.
- RENORM:
  - in_rdy=0.
  - While x >= (c << SYM_WIDTH): present out = x[SYM_WIDTH-1:0], out_vld=1. On accept, x <= x >> SYM_WIDTH.
  - The comparison is re-evaluated each cycle. When false, go to DIV.
- DIV:
  - Sequential restoring divider, x / c, one quotient bit per cycle, STATE_WIDTH cycles.
  - Produces q and r.
- UPDATE (1 cycle): x <= q*M + lo(s) + r.
  - Arithmetic is performed at STATE_WIDTH+CNT_WIDTH+SYM_WIDTH bits; the result is truncated to STATE_WIDTH.
  - With M <= 2^(STATE_WIDTH-SYM_WIDTH) the result lies in [M, M<<SYM_WIDTH), so there is no overflow.
  - If last: go to FLUSH. Otherwise go to IDLE.
- FLUSH:
  - Emit STATE_WIDTH/SYM_WIDTH chunks of x, most significant chunk first.
  - out_last=1 on the final chunk only.
  - After the final accept: frame_active=0, x=0, go to IDLE.
- Latency: symbol accept to next in_rdy = k handshake cycles (k renorm chunks, no backpressure) + STATE_WIDTH divide cycles + 1 update cycle + 1 cycle.
- Table inputs are sampled live and must be held stable for the whole frame.
- ena=0 freezes the FSM, x and the divider. Outputs hold their values; no handshake completes.
- Reset asserted mid-operation (any state, including mid-divide or mid-flush) returns every output and register to its reset value immediately. The partial frame is discarded.
- err is cleared only by reset.

Test Plan:
Tables for all scenarios: count0=8, count1=4, count2=4, all others 0 (M=16, cum = 8,12,16,16,...).
- Single symbol 1 with in_last -> x=72 (0x0048) -> flush emits 0,0,4,8; out_last only on the 8; no renorm chunks.
- Symbols 0 then 0 (last on the second) -> x goes 16 -> 32 -> 64 -> flush emits 0,0,4,0.
- Symbols 1 then 1 (last on the second) -> second symbol renorms: 72 >= 64, emit 8, x=4 -> x=24 -> flush 0,0,1,8. Total stream 8,0,0,1,8; reversed stream decodes to 1,1 in ans_decoder.
- Symbol 5 (count 0) -> err=1, no out_vld, in_rdy stays 1. A following valid symbol 1 with last still yields 0,0,4,8.
- Backpressure: hold out_rdy=0 for 5 cycles during the renorm case -> out=8 and out_vld stay stable; x is unchanged; identical stream after release.
- Drop rst_n during DIV of a symbol -> outputs return to reset values asynchronously. A following single symbol 2 with last yields x=(16/4)*16+12+0=76, emitting 0,0,4,C.
